sm_div_seq: RTL and testbench



---
 rtl/sm_calc_pkg.sv | 26 ++
 rtl/sm_divstep.sv | 29 ++
 rtl/sm_div_seq.sv | 167 ++++++++++++++++
 tb/tb_sm_div_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sm_calc_pkg.sv
// Shared definitions for the sign-magnitude calculator datapath.
//   state_t   : divider FSM states
//   SIGN_BIT  : position of the sign bit in a 3-bit operand
//   MAG_W     : magnitude width
//   sm_canon  : builds a sign-magnitude word, forcing -0 to +0
//   flags_of  : derives {ZF, EF, OF} from a remainder word
package sm_calc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        SIGN = 2'd2
    } state_t;

    localparam int SIGN_BIT = 2;
    localparam int MAG_W    = 2;

    function automatic logic [MAG_W:0] sm_canon(input logic sign, input logic [MAG_W-1:0] mag);
        return {sign & (mag != '0), mag};
    endfunction

    function automatic logic [2:0] flags_of(input logic [MAG_W:0] r);
        return {(r[MAG_W-1:0] == '0), ~r[0], r[0]};
    endfunction

endpackage

// File: rtl/sm_divstep.sv
// One combinational restoring-division step on magnitudes.
//   rem      in  2  running remainder (always < divisor)
//   dbit     in  1  next dividend bit, MSB first
//   divisor  in  2  |B| (non-zero when used)
//   rem_new  out 2  updated remainder
//   qbit     out 1  quotient bit produced by this step
module sm_divstep
    import sm_calc_pkg::*;
(
    input  logic [MAG_W-1:0] rem,
    input  logic             dbit,
    input  logic [MAG_W-1:0] divisor,
    output logic [MAG_W-1:0] rem_new,
    output logic             qbit
);

    logic [MAG_W:0] partial;
    logic [MAG_W:0] diff;

    always_comb begin
        partial = {rem, dbit};
        diff    = partial - {1'b0, divisor};
        qbit    = (partial >= {1'b0, divisor});
        // Since rem < divisor, both the difference and an unsubtracted
        // partial fit in MAG_W bits whenever they are selected.
        rem_new = qbit ? diff[MAG_W-1:0] : partial[MAG_W-1:0];
    end

endmodule

// File: rtl/sm_div_seq.sv
// Sequential 3-bit sign-magnitude divider with start/done handshake.
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   request, sampled only in IDLE
//   A, B   in   3-bit sign-magnitude dividend / divisor
//   busy   out  high from start acceptance until done
//   done   out  one-cycle pulse; Q, R and flags valid from then on
//   Q, R   out  quotient / remainder (truncating, canonical zero)
//   ZF, EF, OF, DZF  out  remainder zero / even / odd, divide by zero
module sm_div_seq
    import sm_calc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] A,
    input  logic [2:0] B,
    output logic       busy,
    output logic       done,
    output logic [2:0] Q,
    output logic [2:0] R,
    output logic       ZF,
    output logic       EF,
    output logic       OF,
    output logic       DZF
);

    state_t            state_reg, state_next;
    logic              a_sign_reg, a_sign_next;
    logic              b_sign_reg, b_sign_next;
    logic [MAG_W-1:0]  a_mag_reg, a_mag_next;
    logic [MAG_W-1:0]  b_mag_reg, b_mag_next;
    logic              cnt_reg, cnt_next;
    logic [MAG_W-1:0]  rem_reg, rem_next;
    logic [MAG_W-1:0]  quo_reg, quo_next;
    logic              dz_reg, dz_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic [2:0]        q_reg, q_next;
    logic [2:0]        r_reg, r_next;
    logic [2:0]        flags_reg, flags_next;   // {ZF, EF, OF}
    logic              dzf_reg, dzf_next;

    logic [MAG_W-1:0]  step_rem;
    logic              step_qbit;

    sm_divstep u_step (
        .rem     (rem_reg),
        .dbit    (a_mag_reg[cnt_reg]),
        .divisor (b_mag_reg),
        .rem_new (step_rem),
        .qbit    (step_qbit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_sign_reg <= 1'b0;
            b_sign_reg <= 1'b0;
            a_mag_reg  <= '0;
            b_mag_reg  <= '0;
            cnt_reg    <= 1'b0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            dz_reg     <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            q_reg      <= '0;
            r_reg      <= '0;
            flags_reg  <= '0;
            dzf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_sign_reg <= a_sign_next;
            b_sign_reg <= b_sign_next;
            a_mag_reg  <= a_mag_next;
            b_mag_reg  <= b_mag_next;
            cnt_reg    <= cnt_next;
            rem_reg    <= rem_next;
            quo_reg    <= quo_next;
            dz_reg     <= dz_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            q_reg      <= q_next;
            r_reg      <= r_next;
            flags_reg  <= flags_next;
            dzf_reg    <= dzf_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        a_sign_next = a_sign_reg;
        b_sign_next = b_sign_reg;
        a_mag_next  = a_mag_reg;
        b_mag_next  = b_mag_reg;
        cnt_next    = cnt_reg;
        rem_next    = rem_reg;
        quo_next    = quo_reg;
        dz_next     = dz_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;
        q_next      = q_reg;
        r_next      = r_reg;
        flags_next  = flags_reg;
        dzf_next    = dzf_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_sign_next = A[SIGN_BIT];
                    b_sign_next = B[SIGN_BIT];
                    a_mag_next  = A[MAG_W-1:0];
                    b_mag_next  = B[MAG_W-1:0];
                    rem_next    = '0;
                    quo_next    = '0;
                    busy_next   = 1'b1;
                    if (B[MAG_W-1:0] == '0) begin
                        dz_next    = 1'b1;
                        state_next = SIGN;
                    end else begin
                        dz_next    = 1'b0;
                        cnt_next   = 1'b1;
                        state_next = ITER;
                    end
                end
            end
            ITER: begin
                rem_next = step_rem;
                quo_next = {quo_reg[0], step_qbit};
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == 1'b0) begin
                    state_next = SIGN;
                end
            end
            SIGN: begin
                if (dz_reg) begin
                    q_next     = '0;
                    r_next     = '0;
                    flags_next = 3'b110;
                    dzf_next   = 1'b1;
                end else begin
                    q_next     = sm_canon(a_sign_reg ^ b_sign_reg, quo_reg);
                    r_next     = sm_canon(a_sign_reg, rem_reg);
                    flags_next = flags_of(sm_canon(a_sign_reg, rem_reg));
                    dzf_next   = 1'b0;
                end
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign Q    = q_reg;
    assign R    = r_reg;
    assign ZF   = flags_reg[2];
    assign EF   = flags_reg[1];
    assign OF   = flags_reg[0];
    assign DZF  = dzf_reg;

endmodule

// File: tb/tb_sm_div_seq.sv
// Self-checking bench for sm_div_seq: directed vector table, back-to-back
// start, mid-operation reset, and an exhaustive sweep against a model.
module tb_sm_div_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] A;
    logic [2:0] B;
    logic       busy;
    logic       done;
    logic [2:0] Q;
    logic [2:0] R;
    logic       ZF, EF, OF, DZF;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] q;
        logic [2:0] r;
        logic       zf;
        logic       ef;
        logic       of;
        logic       dzf;
        int         lat;
    } vec_t;

    sm_div_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Q     (Q),
        .R     (R),
        .ZF    (ZF),
        .EF    (EF),
        .OF    (OF),
        .DZF   (DZF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: truncating division on magnitudes, canonical zero.
    function automatic vec_t model(input logic [2:0] a, input logic [2:0] b);
        vec_t v;
        int am, bm, qm, rm;
        am = int'(a[1:0]);
        bm = int'(b[1:0]);
        v.a = a;
        v.b = b;
        if (bm == 0) begin
            v.q = 3'b000; v.r = 3'b000;
            v.zf = 1'b1; v.ef = 1'b1; v.of = 1'b0; v.dzf = 1'b1;
            v.lat = 1;
        end else begin
            qm = am / bm;
            rm = am % bm;
            v.q = {(a[2] ^ b[2]) && (qm != 0), 2'(qm)};
            v.r = {a[2] && (rm != 0), 2'(rm)};
            v.zf = (rm == 0);
            v.ef = (rm % 2 == 0);
            v.of = (rm % 2 == 1);
            v.dzf = 1'b0;
            v.lat = 3;
        end
        return v;
    endfunction

    task automatic do_op(input vec_t e, input bit verbose);
        int lat;
        string tag;
        tag = $sformatf("A=%b B=%b", e.a, e.b);
        @(negedge clk);
        start = 1'b1; A = e.a; B = e.b;
        @(negedge clk);
        start = 1'b0;
        A = ~e.a; B = ~e.b;   // operands must be ignored while busy
        chk({tag, " busy_after_accept"}, int'(busy), 1);
        lat = 0;
        while (!done && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " done_seen"}, int'(done), 1);
        chk({tag, " latency"}, lat, e.lat);
        chk({tag, " Q"}, int'(Q), int'(e.q));
        chk({tag, " R"}, int'(R), int'(e.r));
        chk({tag, " ZF"}, int'(ZF), int'(e.zf));
        chk({tag, " EF"}, int'(EF), int'(e.ef));
        chk({tag, " OF"}, int'(OF), int'(e.of));
        chk({tag, " DZF"}, int'(DZF), int'(e.dzf));
        chk({tag, " busy_at_done"}, int'(busy), 0);
        @(negedge clk);
        chk({tag, " done_one_cycle"}, int'(done), 0);
        chk({tag, " Q_hold"}, int'(Q), int'(e.q));
        chk({tag, " R_hold"}, int'(R), int'(e.r));
        if (verbose)
            $display("op %s -> Q=%b R=%b ZF=%b EF=%b OF=%b DZF=%b lat=%0d",
                     tag, Q, R, ZF, EF, OF, DZF, lat);
    endtask

    vec_t vecs[8];
    logic [2:0] bb_a[6];
    logic [2:0] bb_b[6];

    initial begin
        vec_t e;
        int n_done;
        rst = 1'b1; start = 1'b0; A = 3'b000; B = 3'b000;

        vecs[0] = '{3'b111, 3'b010, 3'b101, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 3};
        vecs[1] = '{3'b011, 3'b101, 3'b111, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 3};
        vecs[2] = '{3'b010, 3'b100, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 1};
        vecs[3] = '{3'b100, 3'b001, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 3};
        vecs[4] = '{3'b011, 3'b010, 3'b001, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 3};
        vecs[5] = '{3'b110, 3'b011, 3'b000, 3'b110, 1'b0, 1'b1, 1'b0, 1'b0, 3};
        vecs[6] = '{3'b001, 3'b111, 3'b000, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 3};
        vecs[7] = '{3'b011, 3'b001, 3'b011, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 3};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset Q", int'(Q), 0);
        chk("reset R", int'(R), 0);
        chk("reset flags", int'({ZF, EF, OF, DZF}), 0);
        $display("reset: busy=%b done=%b Q=%b R=%b", busy, done, Q, R);
        rst = 1'b0;

        // Directed table
        foreach (vecs[i]) do_op(vecs[i], 1'b1);

        // Back-to-back: start held for 6 cycles with fresh operands each cycle
        bb_a = '{3'b111, 3'b001, 3'b010, 3'b011, 3'b011, 3'b110};
        bb_b = '{3'b010, 3'b011, 3'b111, 3'b001, 3'b110, 3'b001};
        n_done = 0;
        @(negedge clk);
        for (int c = 0; c < 12; c++) begin
            if (c < 6) begin
                start = 1'b1; A = bb_a[c]; B = bb_b[c];
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                e = model(bb_a[(n_done == 0) ? 0 : 4], bb_b[(n_done == 0) ? 0 : 4]);
                chk("b2b done_cycle", c, (n_done == 0) ? 3 : 7);
                chk("b2b Q", int'(Q), int'(e.q));
                chk("b2b R", int'(R), int'(e.r));
                $display("b2b result %0d at cycle %0d: Q=%b R=%b", n_done, c, Q, R);
                n_done++;
            end
        end
        chk("b2b result_count", n_done, 2);

        // Mid-operation reset: leave non-zero outputs first
        do_op(vecs[0], 1'b0);
        @(negedge clk);
        start = 1'b1; A = 3'b011; B = 3'b010;
        @(negedge clk);          // after accept edge k
        start = 1'b0;
        @(negedge clk);          // after edge k+1
        rst = 1'b1;              // asynchronous, lands before edge k+2
        #1;
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        chk("midrst Q", int'(Q), 0);
        chk("midrst R", int'(R), 0);
        chk("midrst flags", int'({ZF, EF, OF, DZF}), 0);
        n_done = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) rst = 1'b0;
            if (done) n_done++;
        end
        chk("midrst no_done", n_done, 0);
        $display("midrst: busy=%b Q=%b R=%b done_pulses=%0d", busy, Q, R, n_done);
        do_op(vecs[4], 1'b1);

        // Exhaustive sweep
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                do_op(model(3'(a), 3'(b)), 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
